// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operation request and result bus bundle for alu_exec_unit
//
// Purpose: carries one operation request (start/opcode/srcA/srcB) into the unit
// and the registered result, flags and strobes back to the requester and bus buffer.
// Ports (signals):
//   start      1   operation request, sampled by the unit only while idle
//   opcode     4   operation select
//   srcA       16  operand A
//   srcB       16  operand B / signed shift count in [4:0]
//   aluResult  16  registered result driven toward the bus buffer
//   busEnable  1   one-cycle bus drive strobe
//   done       1   one-cycle completion pulse
//   busy       1   unit is not idle
//   flags      5   {C, L, F, Z, N}
// modport master: requester side; modport slave: the execution unit.
interface alu_exec_unit_if;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic [15:0] aluResult;
    logic        busEnable;
    logic        done;
    logic        busy;
    logic [4:0]  flags;

    modport master (
        output start, opcode, srcA, srcB,
        input  aluResult, busEnable, done, busy, flags
    );

    modport slave (
        input  start, opcode, srcA, srcB,
        output aluResult, busEnable, done, busy, flags
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - sequential 16-bit execution unit with iterative shift and multiply
//
// Purpose: accepts one operation per start in IDLE, computes single-cycle ops on
// the accepting edge, iterates LSH one bit per cycle and MUL one multiplier bit
// per cycle, and presents result/flags in a one-cycle DRIVE state.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of alu_exec_unit_if (request in, result/flags/strobes out)
module alu_exec_unit (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DRIVE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;          // operand A; multiplicand (shifted left) during MUL
    logic [15:0] b_q, b_d;          // operand B; multiplier (shifted right) during MUL
    logic [15:0] acc_q, acc_d;      // shift register / product accumulator
    logic [4:0]  cnt_q, cnt_d;      // remaining iterations (up to 16)
    logic [15:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;  // {C, L, F, Z, N}
    logic        bus_en_q, bus_en_d;
    logic        done_q, done_d;

    // Single-cycle arithmetic on the live operands, used on the accepting edge.
    logic [16:0] add_full;
    logic [15:0] sub_res;
    logic        add_ovf, sub_ovf, lt_u, lt_s, eq;
    logic [4:0]  shift_k;
    logic [15:0] shift_step, mul_sum;

    assign add_full = {1'b0, bus.srcA} + {1'b0, bus.srcB};
    assign sub_res  = bus.srcA - bus.srcB;
    assign add_ovf  = (bus.srcA[15] == bus.srcB[15]) && (add_full[15] != bus.srcA[15]);
    assign sub_ovf  = (bus.srcA[15] != bus.srcB[15]) && (sub_res[15] != bus.srcA[15]);
    assign lt_u     = bus.srcA < bus.srcB;
    assign lt_s     = $signed(bus.srcA) < $signed(bus.srcB);
    assign eq       = bus.srcA == bus.srcB;
    // Magnitude of the signed 5-bit count; -16 negates to 5'b10000 = 16.
    assign shift_k  = bus.srcB[4] ? (5'd0 - bus.srcB[4:0]) : bus.srcB[4:0];

    // b_q[4] keeps the sign of the captured count: set means shift right.
    assign shift_step = b_q[4] ? {1'b0, acc_q[15:1]} : {acc_q[14:0], 1'b0};
    assign mul_sum    = b_q[0] ? (acc_q + a_q) : acc_q;

    function automatic logic [4:0] set_zn(input logic [4:0] f, input logic [15:0] r);
        set_zn = {f[4:2], (r == 16'd0), r[15]};
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        bus_en_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.srcA;
                    b_d     = bus.srcB;
                    state_d = S_DRIVE;
                    done_d  = 1'b1;
                    case (bus.opcode)
                        OP_ADD: begin
                            result_d = add_full[15:0];
                            flags_d  = {add_full[16], flags_q[3], add_ovf,
                                        (add_full[15:0] == 16'd0), add_full[15]};
                            bus_en_d = 1'b1;
                        end
                        OP_SUB: begin
                            result_d = sub_res;
                            flags_d  = {lt_u, flags_q[3], sub_ovf, (sub_res == 16'd0), sub_res[15]};
                            bus_en_d = 1'b1;
                        end
                        OP_AND: begin
                            result_d = bus.srcA & bus.srcB;
                            flags_d  = set_zn(flags_q, bus.srcA & bus.srcB);
                            bus_en_d = 1'b1;
                        end
                        OP_OR: begin
                            result_d = bus.srcA | bus.srcB;
                            flags_d  = set_zn(flags_q, bus.srcA | bus.srcB);
                            bus_en_d = 1'b1;
                        end
                        OP_XOR: begin
                            result_d = bus.srcA ^ bus.srcB;
                            flags_d  = set_zn(flags_q, bus.srcA ^ bus.srcB);
                            bus_en_d = 1'b1;
                        end
                        OP_CMP: begin
                            flags_d = {flags_q[4], lt_u, flags_q[2], eq, lt_s};
                        end
                        OP_MOV: begin
                            result_d = bus.srcB;
                            flags_d  = set_zn(flags_q, bus.srcB);
                            bus_en_d = 1'b1;
                        end
                        OP_LSH: begin
                            if (shift_k == 5'd0) begin
                                result_d = bus.srcA;
                                flags_d  = set_zn(flags_q, bus.srcA);
                                bus_en_d = 1'b1;
                            end else begin
                                acc_d   = bus.srcA;
                                cnt_d   = shift_k;
                                state_d = S_SHIFT;
                                done_d  = 1'b0;
                            end
                        end
                        OP_MUL: begin
                            acc_d   = 16'd0;
                            cnt_d   = 5'd16;
                            state_d = S_MUL;
                            done_d  = 1'b0;
                        end
                        default: ;  // NOP: done only, nothing else changes
                    endcase
                end
            end
            S_SHIFT: begin
                acc_d = shift_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shift_step;
                    flags_d  = set_zn(flags_q, shift_step);
                    bus_en_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DRIVE;
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                a_d   = {a_q[14:0], 1'b0};
                b_d   = {1'b0, b_q[15:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = mul_sum;
                    flags_d  = set_zn(flags_q, mul_sum);
                    bus_en_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            bus_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            bus_en_q <= bus_en_d;
            done_q   <= done_d;
        end
    end

    assign bus.aluResult = result_q;
    assign bus.busEnable = bus_en_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_exec_unit_if bus_if ();

    alu_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  flg;
        logic        be;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int done_cnt;
        int be_cnt;
        int done_at;

        bus_if.start  = 1'b0;
        bus_if.opcode = 4'd0;
        bus_if.srcA   = 16'd0;
        bus_if.srcB   = 16'd0;

        //            op     a         b         res       flags     be  lat
        vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1'b1, 0};
        vecs[1]  = '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 5'b10001, 1'b1, 0};
        vecs[2]  = '{4'd5,  16'h0003, 16'h0005, 16'hFFFE, 5'b11001, 1'b0, 0};
        vecs[3]  = '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b11000, 1'b1, 0};
        vecs[4]  = '{4'd3,  16'h0000, 16'h0000, 16'h0000, 5'b11010, 1'b1, 0};
        vecs[5]  = '{4'd4,  16'hFFFF, 16'h00FF, 16'hFF00, 5'b11001, 1'b1, 0};
        vecs[6]  = '{4'd6,  16'hAAAA, 16'h1234, 16'h1234, 5'b11000, 1'b1, 0};
        vecs[7]  = '{4'hC,  16'h0001, 16'h0002, 16'h1234, 5'b11000, 1'b0, 0};
        vecs[8]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b11010, 1'b1, 0};
        vecs[9]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 5'b01100, 1'b1, 0};
        vecs[10] = '{4'd5,  16'h0005, 16'h0005, 16'h7FFF, 5'b00110, 1'b0, 0};
        vecs[11] = '{4'd5,  16'h8000, 16'h0001, 16'h7FFF, 5'b00101, 1'b0, 0};
        vecs[12] = '{4'd7,  16'h8001, 16'h001F, 16'h4000, 5'b00100, 1'b1, 1};
        vecs[13] = '{4'd7,  16'h0001, 16'h0003, 16'h0008, 5'b00100, 1'b1, 3};
        vecs[14] = '{4'd7,  16'h1234, 16'h0000, 16'h1234, 5'b00100, 1'b1, 0};
        vecs[15] = '{4'd7,  16'hFFFF, 16'h0010, 16'h0000, 5'b00110, 1'b1, 16};
        vecs[16] = '{4'd7,  16'h0001, 16'h000F, 16'h8000, 5'b00101, 1'b1, 15};
        vecs[17] = '{4'd8,  16'h0100, 16'h0101, 16'h0100, 5'b00100, 1'b1, 16};
        vecs[18] = '{4'd8,  16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100, 1'b1, 16};
        vecs[19] = '{4'd1,  16'h0005, 16'h0003, 16'h0002, 5'b00000, 1'b1, 0};

        tick();
        tick();
        chk("rst_result", 32'(bus_if.aluResult), 32'h0);
        chk("rst_flags",  32'(bus_if.flags), 32'h0);
        chk("rst_busy",   32'(bus_if.busy), 32'h0);
        chk("rst_done",   32'(bus_if.done), 32'h0);
        chk("rst_be",     32'(bus_if.busEnable), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            bus_if.opcode = vecs[i].op;
            bus_if.srcA   = vecs[i].a;
            bus_if.srcB   = vecs[i].b;
            bus_if.start  = 1'b1;
            tick();
            bus_if.start = 1'b0;
            lat = 0;
            while (!bus_if.done && lat < 40) begin
                chk($sformatf("v%0d_busy_iter", i), 32'(bus_if.busy), 32'h1);
                chk($sformatf("v%0d_be_early", i), 32'(bus_if.busEnable), 32'h0);
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), 32'(bus_if.aluResult), 32'(vecs[i].res));
            chk($sformatf("v%0d_flags", i), 32'(bus_if.flags), 32'(vecs[i].flg));
            chk($sformatf("v%0d_busen", i), 32'(bus_if.busEnable), 32'(vecs[i].be));
            chk($sformatf("v%0d_busy_drive", i), 32'(bus_if.busy), 32'h1);
            tick();
            chk($sformatf("v%0d_done_after", i), 32'(bus_if.done), 32'h0);
            chk($sformatf("v%0d_be_after", i), 32'(bus_if.busEnable), 32'h0);
            chk($sformatf("v%0d_busy_after", i), 32'(bus_if.busy), 32'h0);
            chk($sformatf("v%0d_result_hold", i), 32'(bus_if.aluResult), 32'(vecs[i].res));
        end

        // MUL with start pulses during the iteration and during DRIVE: both ignored.
        bus_if.opcode = 4'd8;
        bus_if.srcA   = 16'h0100;
        bus_if.srcB   = 16'h0101;
        bus_if.start  = 1'b1;
        tick();
        bus_if.opcode = 4'd0;
        bus_if.srcA   = 16'h1111;
        bus_if.srcB   = 16'h2222;
        done_cnt = 0;
        be_cnt   = 0;
        done_at  = 0;
        for (int c = 1; c <= 22; c++) begin
            bus_if.start = (c == 3 || c == 17);
            if (bus_if.done) begin
                done_cnt++;
                done_at = c;
            end
            if (bus_if.busEnable) be_cnt++;
            if (c == 17) chk("mulign_result", 32'(bus_if.aluResult), 32'h0100);
            if (c == 17) chk("mulign_zflag", 32'(bus_if.flags[1]), 32'h0);
            if (c == 18) chk("mulign_busy18", 32'(bus_if.busy), 32'h0);
            tick();
        end
        bus_if.start = 1'b0;
        chk("mulign_done_cnt", 32'(done_cnt), 32'h1);
        chk("mulign_done_at", 32'(done_at), 32'd17);
        chk("mulign_be_cnt", 32'(be_cnt), 32'h1);
        chk("mulign_result_end", 32'(bus_if.aluResult), 32'h0100);

        // Reset in the middle of a MUL aborts it silently.
        bus_if.opcode = 4'd8;
        bus_if.srcA   = 16'h0003;
        bus_if.srcB   = 16'h0005;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy",   32'(bus_if.busy), 32'h0);
        chk("midrst_result", 32'(bus_if.aluResult), 32'h0);
        chk("midrst_flags",  32'(bus_if.flags), 32'h0);
        done_cnt = 0;
        be_cnt   = 0;
        for (int c = 0; c < 24; c++) begin
            if (bus_if.done) done_cnt++;
            if (bus_if.busEnable) be_cnt++;
            tick();
        end
        chk("midrst_no_done", 32'(done_cnt), 32'h0);
        chk("midrst_no_be",   32'(be_cnt), 32'h0);
        chk("midrst_busy_end", 32'(bus_if.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential 16-bit execution unit sitting directly upstream of the ALU bus-drive buffer. Accepts one operation per start pulse, computes single-cycle ops in one cycle and shift/multiply ops iteratively, then holds the result and the PSR-style flags in registers. `aluResult` feeds the buffer's data input and `busEnable` feeds its enable, so the unit owns the shared 16-bit bus for exactly one cycle per result-producing operation.

## Interface
- No parameters; the datapath width is fixed at 16.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: operation request; sampled only in IDLE.
- `opcode` in 4: operation select, captured on an accepted start.
- `srcA` in 16: operand A, captured on an accepted start.
- `srcB` in 16: operand B or shift amount, captured on an accepted start.
- `aluResult` out 16: registered result to the bus buffer; holds its value between operations.
- `busEnable` out 1: one-cycle drive strobe to the bus buffer.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high whenever the state is not IDLE.
- `flags` out 5: registered flags {C, L, F, Z, N}, bit 4 down to bit 0.

## Operation
States: IDLE, SHIFT, MUL, DRIVE.
- IDLE + start: capture opcode, srcA and srcB, then branch by opcode:
  - Single-cycle ops go to DRIVE.
  - LSH goes to SHIFT, or directly to DRIVE if the shift count is 0.
  - MUL goes to MUL.
- SHIFT: shift by one bit per cycle; decrement the count; go to DRIVE when the count reaches 0.
- MUL: shift-add, one multiplier bit per cycle for 16 cycles; then go to DRIVE.
- DRIVE: write aluResult and flags; pulse done; pulse busEnable if the op produces a result; return to IDLE.

Opcodes:
- 0 ADD: A+B.
- 1 SUB: A−B.
- 2 AND, 3 OR, 4 XOR.
- 5 CMP: flags only.
- 6 MOV: result = B.
- 7 LSH: srcB[4:0] is a signed count from −16 to +15. Positive shifts left; negative shifts right logical. Count magnitude is k.
- 8 MUL: low 16 bits of the unsigned product.
- 9–15: NOP.

Flag rules (flags not listed for an op are kept):
- ADD: C = carry out; F = signed overflow; Z = (result==0); N = result[15].
- SUB: C = borrow (A<B unsigned); F = signed overflow; Z; N.
- CMP: L = (A<B unsigned); N = (A<B signed); Z = (A==B). aluResult is unchanged and busEnable is not asserted.
- AND/OR/XOR/MOV/LSH/MUL: Z and N from the result; C, L and F are kept.
- NOP: done pulses; no flag change, no result change, no busEnable.

General rules:
- All arithmetic is modulo 2^16.
- A shift of 16 or more positions yields 0.

## Timing
- Reset values: aluResult=0, flags=0, busEnable=0, done=0, busy=0, state=IDLE.
- Reset has priority over every other event in every state. A mid-operation reset aborts the op and produces no done and no busEnable.
- Start is accepted at edge N while in IDLE. busy is high from cycle N+1 through the DRIVE cycle inclusive.
- Latency to the DRIVE cycle (done high, busEnable high, new aluResult visible):
  - Single-cycle ops and NOP: N+1.
  - LSH with k=0: N+1.
  - LSH with k>0: N+k+1.
  - MUL: N+17.
- aluResult and flags change only on the edge that enters DRIVE. They are stable for the whole busEnable cycle and afterwards.
- start while not in IDLE, including during DRIVE, is ignored and never queued. The earliest next acceptance is the cycle after DRIVE, which gives back-to-back single-cycle ops one result every 2 cycles.
- busEnable is never high outside DRIVE; done and busEnable are never high for more than one cycle.

## Test plan
- Reset then ADD 0x7FFF+0x0001 → at N+1: aluResult=0x8000, F=1, N=1, Z=0, C=0, done=busEnable=1 for one cycle; busy low at N+2.
- SUB 0x0003−0x0005 then CMP 0x0003,0x0005 →
  - SUB: aluResult=0xFFFE, C=1, N=1.
  - CMP: L=1, N=1, Z=0, aluResult still 0xFFFE, busEnable stays 0.
- LSH A=0x8001, B=0x1F (−1) → done at N+2 with aluResult=0x4000. LSH B=0x03 → done at N+4 with aluResult=0x0008 for A=0x0001.
- MUL 0x0100×0x0101 → done at N+17 with aluResult=0x0100 and Z=0. start pulses at N+3 and N+17 are both ignored, with no second done.
- Reset asserted at N+8 of a MUL → next cycle busy=0, aluResult=0, flags=0, and no done/busEnable ever follows.
- Opcode 0xC → done at N+1, busEnable=0, and flags and aluResult unchanged.
